// File: rtl/mtimer.sv
`default_nettype none
// ============================================================================
//  Module      : mtimer
//  Description : Memory-mapped RISC-V machine timer (mtime / mtimecmp) that
//                sits on the core's data-memory slave port. It has a
//                programmable prescaler and a level-sensitive machine timer
//                interrupt that drives core_top.irq_timer_i.
//
//  Register map (word offset addr_i[2:0], upper address bits alias):
//      0 : MTIME_LO      mtime[31:0]
//      1 : MTIME_HI      mtime[63:32]
//      2 : MTIMECMP_LO   mtimecmp[31:0]
//      3 : MTIMECMP_HI   mtimecmp[63:32]
//      4 : CTRL          bit0 = EN, bits[8+DIV_W-1:8] = DIV, others read 0
//      5..7              unmapped: read 0, writes ignored
//
//  Ports:
//      clk_i        in   1       clock
//      rstn_i       in   1       asynchronous active-low reset
//      ena_i        in   1       slave select from the address decoder
//      read_i       in   1       read strobe, qualified by ena_i
//      addr_i       in   ADDR_W  word address (only [2:0] decoded)
//      wsel_byte_i  in   4       byte write enables
//      wdata_i      in   32      write data
//      rdata_o      out  32      registered read data (1-cycle latency)
//      irq_timer_o  out  1       machine timer interrupt, registered level
//
//  Revision    : 1.0 - initial release
// ============================================================================
module mtimer #(
    parameter int ADDR_W = 30,
    parameter int DIV_W  = 8
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              ena_i,
    input  logic              read_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [3:0]        wsel_byte_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o,
    output logic              irq_timer_o
);

    // ------------------------------------------------------------------------
    // Register offsets and reset values
    // ------------------------------------------------------------------------
    localparam logic [2:0]  c_OFF_MTIME_LO    = 3'd0;
    localparam logic [2:0]  c_OFF_MTIME_HI    = 3'd1;
    localparam logic [2:0]  c_OFF_MTIMECMP_LO = 3'd2;
    localparam logic [2:0]  c_OFF_MTIMECMP_HI = 3'd3;
    localparam logic [2:0]  c_OFF_CTRL        = 3'd4;

    localparam logic [63:0] c_MTIMECMP_RST    = 64'hFFFF_FFFF_FFFF_FFFF;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [63:0]      r_mtime;
    logic [63:0]      r_mtimecmp;
    logic             r_en;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_pcnt;
    logic [31:0]      r_rdata;
    logic             r_irq;

    // ------------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------------
    logic [2:0]       w_off;
    logic             w_rd;
    logic             w_wr;
    logic             w_wr_mtime_lo;
    logic             w_wr_mtime_hi;
    logic             w_wr_cmp_lo;
    logic             w_wr_cmp_hi;
    logic             w_wr_ctrl;

    assign w_off         = addr_i[2:0];
    assign w_rd          = ena_i & read_i;
    assign w_wr          = ena_i & (|wsel_byte_i);
    assign w_wr_mtime_lo = w_wr && (w_off == c_OFF_MTIME_LO);
    assign w_wr_mtime_hi = w_wr && (w_off == c_OFF_MTIME_HI);
    assign w_wr_cmp_lo   = w_wr && (w_off == c_OFF_MTIMECMP_LO);
    assign w_wr_cmp_hi   = w_wr && (w_off == c_OFF_MTIMECMP_HI);
    assign w_wr_ctrl     = w_wr && (w_off == c_OFF_CTRL);

    // Upper address bits are deliberately not decoded, so the register block
    // aliases throughout its decoder window.
    generate
        if (ADDR_W > 3) begin : g_addr_alias
            logic w_unused_addr_hi;
            assign w_unused_addr_hi = ^addr_i[ADDR_W-1:3];
        end
    endgenerate

    // Byte-lane merge: each enabled lane takes the new byte, others keep old.
    function automatic logic [31:0] f_merge(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  be
    );
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return res;
    endfunction

    // ------------------------------------------------------------------------
    // Prescaler
    // ------------------------------------------------------------------------
    logic             w_tick;
    logic [DIV_W-1:0] w_pcnt_nxt;

    assign w_tick = r_en && (r_pcnt == r_div);

    always_comb begin
        w_pcnt_nxt = r_pcnt;
        if (w_wr_ctrl) begin
            // Reprogramming the divider restarts the prescale period cleanly.
            w_pcnt_nxt = '0;
        end else if (r_en) begin
            w_pcnt_nxt = w_tick ? '0 : r_pcnt + DIV_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // CTRL write data. DIV occupies bits starting at 8, so each DIV bit is
    // steered by the byte lane that contains it.
    // ------------------------------------------------------------------------
    logic             w_en_nxt;
    logic [DIV_W-1:0] w_div_wr;

    assign w_en_nxt = (w_wr_ctrl && wsel_byte_i[0]) ? wdata_i[0] : r_en;

    generate
        for (genvar i = 0; i < DIV_W; i++) begin : g_div_bits
            localparam int c_LANE = (8 + i) / 8;
            assign w_div_wr[i] = wsel_byte_i[c_LANE] ? wdata_i[8+i] : r_div[i];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // mtime / mtimecmp next state
    // ------------------------------------------------------------------------
    logic [63:0] w_mtime_nxt;
    logic [63:0] w_mtimecmp_nxt;

    always_comb begin
        w_mtime_nxt = r_mtime;
        if (w_wr_mtime_lo || w_wr_mtime_hi) begin
            // A software write to mtime wins over the tick: the written bytes
            // are merged into the un-incremented value.
            if (w_wr_mtime_lo) begin
                w_mtime_nxt[31:0]  = f_merge(r_mtime[31:0], wdata_i, wsel_byte_i);
            end
            if (w_wr_mtime_hi) begin
                w_mtime_nxt[63:32] = f_merge(r_mtime[63:32], wdata_i, wsel_byte_i);
            end
        end else if (w_tick) begin
            w_mtime_nxt = r_mtime + 64'd1;
        end
    end

    always_comb begin
        w_mtimecmp_nxt = r_mtimecmp;
        if (w_wr_cmp_lo) begin
            w_mtimecmp_nxt[31:0]  = f_merge(r_mtimecmp[31:0], wdata_i, wsel_byte_i);
        end
        if (w_wr_cmp_hi) begin
            w_mtimecmp_nxt[63:32] = f_merge(r_mtimecmp[63:32], wdata_i, wsel_byte_i);
        end
    end

    // ------------------------------------------------------------------------
    // Read mux (current register values, i.e. read-before-write)
    // ------------------------------------------------------------------------
    logic [31:0] w_ctrl_word;
    logic [31:0] w_rd_mux;

    always_comb begin
        w_ctrl_word             = '0;
        w_ctrl_word[0]          = r_en;
        w_ctrl_word[8 +: DIV_W] = r_div;
    end

    always_comb begin
        w_rd_mux = '0;
        case (w_off)
            c_OFF_MTIME_LO:    w_rd_mux = r_mtime[31:0];
            c_OFF_MTIME_HI:    w_rd_mux = r_mtime[63:32];
            c_OFF_MTIMECMP_LO: w_rd_mux = r_mtimecmp[31:0];
            c_OFF_MTIMECMP_HI: w_rd_mux = r_mtimecmp[63:32];
            c_OFF_CTRL:        w_rd_mux = w_ctrl_word;
            default:           w_rd_mux = '0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_mtime    <= '0;
            r_mtimecmp <= c_MTIMECMP_RST;
            r_en       <= 1'b1;
            r_div      <= '0;
            r_pcnt     <= '0;
            r_rdata    <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_mtime    <= w_mtime_nxt;
            r_mtimecmp <= w_mtimecmp_nxt;
            r_pcnt     <= w_pcnt_nxt;
            r_en       <= w_en_nxt;
            if (w_wr_ctrl) begin
                r_div <= w_div_wr;
            end
            if (w_rd) begin
                r_rdata <= w_rd_mux;
            end
            // Compare uses the values held before this edge, so the interrupt
            // follows the condition by exactly one cycle.
            r_irq      <= (r_mtime >= r_mtimecmp);
        end
    end

    assign rdata_o     = r_rdata;
    assign irq_timer_o = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_mtimer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mtimer
//  Description : Self-checking bench for mtimer. Read expectations go into a
//                scoreboard queue; a monitor compares them against rdata_o
//                one cycle after each accepted read. Interrupt and reset
//                behaviour are checked directly.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mtimer;

    localparam int ADDR_W = 30;
    localparam int DIV_W  = 8;

    logic              clk_i;
    logic              rstn_i;
    logic              ena_i;
    logic              read_i;
    logic [ADDR_W-1:0] addr_i;
    logic [3:0]        wsel_byte_i;
    logic [31:0]       wdata_i;
    logic [31:0]       rdata_o;
    logic              irq_timer_o;

    mtimer #(.ADDR_W(ADDR_W), .DIV_W(DIV_W)) u_dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .ena_i       (ena_i),
        .read_i      (read_i),
        .addr_i      (addr_i),
        .wsel_byte_i (wsel_byte_i),
        .wdata_i     (wdata_i),
        .rdata_o     (rdata_o),
        .irq_timer_o (irq_timer_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];
    logic        r_rd_issued;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: a read accepted at a rising edge is visible on rdata_o after it.
    always @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) r_rd_issued <= 1'b0;
        else         r_rd_issued <= ena_i & read_i;
    end

    always @(negedge clk_i) begin
        if (r_rd_issued) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_read: got %h expected no read data", rdata_o);
            end else begin
                check(name_q.pop_front(), rdata_o, exp_q.pop_front());
            end
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic do_read(input string name, input logic [2:0] off, input logic [31:0] exp);
        addr_i      = {27'h5A5, off};
        ena_i       = 1'b1;
        read_i      = 1'b1;
        wsel_byte_i = 4'h0;
        exp_q.push_back(exp);
        name_q.push_back(name);
        @(posedge clk_i);
        #1;
        ena_i  = 1'b0;
        read_i = 1'b0;
    endtask

    task automatic do_write(input logic [2:0] off, input logic [3:0] be, input logic [31:0] data);
        addr_i      = {27'h0, off};
        ena_i       = 1'b1;
        read_i      = 1'b0;
        wsel_byte_i = be;
        wdata_i     = data;
        @(posedge clk_i);
        #1;
        ena_i       = 1'b0;
        wsel_byte_i = 4'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn_i      = 1'b0;
        ena_i       = 1'b0;
        read_i      = 1'b0;
        addr_i      = '0;
        wsel_byte_i = 4'h0;
        wdata_i     = 32'h0;
        repeat (3) @(posedge clk_i);
        #1;
        check("reset_rdata", rdata_o, 32'h0);
        check("reset_irq", {31'h0, irq_timer_o}, 32'h0);
        rstn_i = 1'b1;

        // Free-running count from reset
        idle(10);
        do_read("idle_mtime_lo", 3'd0, 32'd10);
        do_read("idle_mtime_hi", 3'd1, 32'd0);
        check("idle_irq", {31'h0, irq_timer_o}, 32'h0);

        // Carry from LO into HI
        do_write(3'd0, 4'hF, 32'hFFFF_FFFE);
        do_write(3'd1, 4'hF, 32'h0);
        idle(3);
        do_read("carry_lo", 3'd0, 32'h0000_0001);
        do_read("carry_hi", 3'd1, 32'h0000_0001);

        // Interrupt assert / deassert
        do_write(3'd1, 4'hF, 32'h0);
        do_write(3'd0, 4'hF, 32'h0);            // mtime = 0
        do_write(3'd3, 4'hF, 32'h0);            // mtime = 1
        do_write(3'd2, 4'hF, 32'd20);           // mtime = 2
        idle(18);                               // mtime = 20
        check("irq_before_match", {31'h0, irq_timer_o}, 32'h0);
        idle(1);
        check("irq_asserted", {31'h0, irq_timer_o}, 32'h1);
        do_write(3'd2, 4'hF, 32'd100);
        check("irq_held_one_cycle", {31'h0, irq_timer_o}, 32'h1);
        idle(1);
        check("irq_deasserted", {31'h0, irq_timer_o}, 32'h0);

        // Prescaler DIV=3: one tick every 4 cycles
        do_write(3'd0, 4'hF, 32'h0000_1000);
        do_write(3'd4, 4'hF, 32'h0000_0301);    // old DIV=0 still ticks: 0x1001
        idle(3);
        do_read("div3_a", 3'd0, 32'h0000_1001);
        idle(3);
        do_read("div3_b", 3'd0, 32'h0000_1002);
        do_read("div3_c", 3'd0, 32'h0000_1003);
        do_read("ctrl_div3", 3'd4, 32'h0000_0301);

        // EN=0 freezes mtime
        do_write(3'd4, 4'hF, 32'h0);
        idle(20);
        do_read("frozen_hi", 3'd1, 32'h0);
        do_read("frozen_lo", 3'd0, 32'h0000_1003);
        idle(3);
        check("rdata_hold", rdata_o, 32'h0000_1003);

        // Byte-lane write on a tick cycle suppresses the increment
        do_write(3'd4, 4'hF, 32'h0000_0001);
        do_write(3'd0, 4'b0010, 32'h0000_AB00);
        do_read("byte_merge_lo", 3'd0, 32'h0000_AB03);
        check("irq_high_before_reset", {31'h0, irq_timer_o}, 32'h1);

        // Reset with a read in flight
        addr_i = 30'd0;
        ena_i  = 1'b1;
        read_i = 1'b1;
        #6;
        rstn_i = 1'b0;
        ena_i  = 1'b0;
        read_i = 1'b0;
        #1;
        check("async_reset_rdata", rdata_o, 32'h0);
        check("async_reset_irq", {31'h0, irq_timer_o}, 32'h0);
        repeat (2) @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
        do_read("post_reset_cmp_lo", 3'd2, 32'hFFFF_FFFF);
        do_read("post_reset_cmp_hi", 3'd3, 32'hFFFF_FFFF);
        do_read("post_reset_ctrl", 3'd4, 32'h0000_0001);
        do_read("post_reset_mtime", 3'd0, 32'd3);
        do_read("unmapped_read", 3'd6, 32'h0);
        do_write(3'd6, 4'hF, 32'hFFFF_FFFF);
        do_read("unmapped_after_wr", 3'd6, 32'h0);
        do_read("ctrl_after_unmapped_wr", 3'd4, 32'h0000_0001);
        do_read("cmp_after_unmapped_wr", 3'd2, 32'hFFFF_FFFF);
        do_read("mtime_after_unmapped_wr", 3'd1, 32'h0);
        check("post_reset_irq", {31'h0, irq_timer_o}, 32'h0);

        idle(2);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
